// File: rtl/ct_mmu_dutlb_refill_ctrl_pkg.sv
// Shared definitions for the data uTLB refill controller: widths, page-size
// encodings, FSM state encoding and the victim pointer step helper.
package ct_mmu_dutlb_refill_ctrl_pkg;

  localparam int ENTRY_NUM = 8;
  localparam int PTR_W     = $clog2(ENTRY_NUM);
  localparam int VPN_WIDTH = 27;
  localparam int PPN_WIDTH = 28;
  localparam int FLG_WIDTH = 14;
  localparam int PGS_WIDTH = 3;

  localparam logic [PGS_WIDTH-1:0] PGS_4K = 3'b001;
  localparam logic [PGS_WIDTH-1:0] PGS_2M = 3'b010;
  localparam logic [PGS_WIDTH-1:0] PGS_1G = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DROP = 3'd3,
    ST_UPD  = 3'd4
  } refill_state_e;

  // Round-robin pointer step with wrap at the last normal entry
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(ENTRY_NUM - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/ct_mmu_dutlb_victim_sel.sv
// Victim selection for the normal data uTLB entries: the lowest-index
// invalid entry wins; when every entry is valid the round-robin pointer
// chooses. Purely combinational.
module ct_mmu_dutlb_victim_sel
  import ct_mmu_dutlb_refill_ctrl_pkg::*;
(
  input  logic [ENTRY_NUM-1:0] utlb_entry_vld,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [ENTRY_NUM-1:0] victim_oh,
  output logic                 victim_use_rr
);

  logic found;

  // Priority scan for the first free slot, falling back to rr_ptr
  always_comb begin
    victim_oh = '0;
    found     = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (!found && !utlb_entry_vld[i]) begin
        victim_oh[i] = 1'b1;
        found        = 1'b1;
      end
    end
    victim_use_rr = !found;
    if (!found) begin
      victim_oh[rr_ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/ct_mmu_dutlb_refill_ctrl.sv
// Data uTLB refill controller: captures a miss, requests a jTLB lookup,
// writes the returned translation into a victim entry (or the huge entry)
// and tolerates flushes/invalidates arriving mid-refill.
module ct_mmu_dutlb_refill_ctrl
  import ct_mmu_dutlb_refill_ctrl_pkg::*;
(
  input  logic                 utlb_entry_clk,
  input  logic                 cpurst_b,
  input  logic                 utlb_miss_vld,
  input  logic [VPN_WIDTH-1:0] utlb_miss_vpn,
  input  logic [ENTRY_NUM-1:0] utlb_entry_vld,
  input  logic                 regs_utlb_clr,
  input  logic                 tlboper_utlb_clr,
  input  logic                 tlboper_utlb_inv_va_req,
  output logic                 utlb_jtlb_req,
  output logic [VPN_WIDTH-1:0] utlb_jtlb_vpn,
  input  logic                 jtlb_utlb_grant,
  input  logic                 jtlb_utlb_resp_vld,
  input  logic                 jtlb_utlb_resp_fault,
  input  logic [PPN_WIDTH-1:0] jtlb_utlb_resp_ppn,
  input  logic [FLG_WIDTH-1:0] jtlb_utlb_resp_flg,
  input  logic [PGS_WIDTH-1:0] jtlb_utlb_resp_pgs,
  output logic [ENTRY_NUM-1:0] utlb_entry_upd,
  output logic                 utlb_huge_entry_upd,
  output logic [VPN_WIDTH-1:0] utlb_upd_vpn,
  output logic [PPN_WIDTH-1:0] utlb_upd_ppn,
  output logic [FLG_WIDTH-1:0] utlb_upd_flg,
  output logic [PGS_WIDTH-1:0] utlb_upd_pgs,
  output logic                 utlb_refill_busy,
  output logic                 utlb_refill_done,
  output logic                 utlb_refill_fault
);

  refill_state_e        state;
  logic [VPN_WIDTH-1:0] req_vpn;
  logic [PPN_WIDTH-1:0] upd_ppn_q;
  logic [FLG_WIDTH-1:0] upd_flg_q;
  logic [PGS_WIDTH-1:0] upd_pgs_q;
  logic [ENTRY_NUM-1:0] upd_oh_q;
  logic                 upd_huge_q;
  logic                 upd_used_rr_q;
  logic                 fault_q;
  logic [PTR_W-1:0]     rr_ptr;

  logic                 flush;
  logic                 upd_live;
  logic [ENTRY_NUM-1:0] victim_oh;
  logic                 victim_use_rr;
  logic                 resp_huge;

  assign flush     = regs_utlb_clr | tlboper_utlb_clr | tlboper_utlb_inv_va_req;
  assign resp_huge = (jtlb_utlb_resp_pgs == PGS_1G);

  ct_mmu_dutlb_victim_sel x_victim_sel (
    .utlb_entry_vld (utlb_entry_vld),
    .rr_ptr         (rr_ptr),
    .victim_oh      (victim_oh),
    .victim_use_rr  (victim_use_rr)
  );

  // Refill FSM with its captured request/response data and victim pointer
  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state         <= ST_IDLE;
      req_vpn       <= '0;
      upd_ppn_q     <= '0;
      upd_flg_q     <= '0;
      upd_pgs_q     <= '0;
      upd_oh_q      <= '0;
      upd_huge_q    <= 1'b0;
      upd_used_rr_q <= 1'b0;
      fault_q       <= 1'b0;
      rr_ptr        <= '0;
    end else begin
      fault_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A miss that coincides with the fault pulse is the one just
          // answered; it is only taken once the pulse has gone.
          if (utlb_miss_vld && !flush && !fault_q) begin
            req_vpn <= utlb_miss_vpn;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (jtlb_utlb_grant) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            state <= ST_DROP;
          end else if (jtlb_utlb_resp_vld && jtlb_utlb_resp_fault) begin
            fault_q <= 1'b1;
            state   <= ST_IDLE;
          end else if (jtlb_utlb_resp_vld) begin
            upd_ppn_q     <= jtlb_utlb_resp_ppn;
            upd_flg_q     <= jtlb_utlb_resp_flg;
            upd_pgs_q     <= jtlb_utlb_resp_pgs;
            upd_huge_q    <= resp_huge;
            upd_oh_q      <= resp_huge ? '0 : victim_oh;
            upd_used_rr_q <= !resp_huge && victim_use_rr;
            state         <= ST_UPD;
          end
        end
        ST_DROP: begin
          if (jtlb_utlb_resp_vld) begin
            state <= ST_IDLE;
          end
        end
        ST_UPD: begin
          if (!flush && upd_used_rr_q) begin
            rr_ptr <= rr_next(rr_ptr);
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output decode: strobes live only in UPD and are killed by a same-cycle flush
  always_comb begin
    upd_live            = (state == ST_UPD) && !flush;
    utlb_jtlb_req       = (state == ST_REQ);
    utlb_jtlb_vpn       = req_vpn;
    utlb_entry_upd      = upd_live ? upd_oh_q : '0;
    utlb_huge_entry_upd = upd_live && upd_huge_q;
    utlb_upd_vpn        = req_vpn;
    utlb_upd_ppn        = upd_ppn_q;
    utlb_upd_flg        = upd_flg_q;
    utlb_upd_pgs        = upd_pgs_q;
    utlb_refill_busy    = (state != ST_IDLE);
    utlb_refill_done    = upd_live;
    utlb_refill_fault   = fault_q;
  end

endmodule

// File: tb/tb_ct_mmu_dutlb_refill_ctrl.sv
// Bench for the data uTLB refill controller: scripted transactions drive
// the block while a per-cycle checker compares every output against the
// expectations the transaction model computes.
module tb_ct_mmu_dutlb_refill_ctrl;

  logic        clk = 1'b0;
  logic        cpurst_b;
  logic        miss_vld;
  logic [26:0] miss_vpn;
  logic [7:0]  entry_vld;
  logic        regs_clr, tlb_clr, inv_req;
  logic        jtlb_req;
  logic [26:0] jtlb_vpn;
  logic        grant, resp_vld, resp_fault;
  logic [27:0] resp_ppn;
  logic [13:0] resp_flg;
  logic [2:0]  resp_pgs;
  logic [7:0]  entry_upd;
  logic        huge_upd;
  logic [26:0] upd_vpn;
  logic [27:0] upd_ppn;
  logic [13:0] upd_flg;
  logic [2:0]  upd_pgs;
  logic        busy, done, fault;

  int total = 0;
  int bad   = 0;

  // expectations for the current cycle
  logic        exp_busy, exp_req, exp_done, exp_fault, exp_huge, exp_data;
  logic [7:0]  exp_upd;
  logic [26:0] exp_vpn;
  logic [27:0] exp_ppn;
  logic [13:0] exp_flg;
  logic [2:0]  exp_pgs;

  // model state and what the DUT actually wrote on its last done
  int          model_rr;
  logic [7:0]  seen_upd;
  logic        seen_huge;
  logic [7:0]  pred;

  ct_mmu_dutlb_refill_ctrl dut (
    .utlb_entry_clk          (clk),
    .cpurst_b                (cpurst_b),
    .utlb_miss_vld           (miss_vld),
    .utlb_miss_vpn           (miss_vpn),
    .utlb_entry_vld          (entry_vld),
    .regs_utlb_clr           (regs_clr),
    .tlboper_utlb_clr        (tlb_clr),
    .tlboper_utlb_inv_va_req (inv_req),
    .utlb_jtlb_req           (jtlb_req),
    .utlb_jtlb_vpn           (jtlb_vpn),
    .jtlb_utlb_grant         (grant),
    .jtlb_utlb_resp_vld      (resp_vld),
    .jtlb_utlb_resp_fault    (resp_fault),
    .jtlb_utlb_resp_ppn      (resp_ppn),
    .jtlb_utlb_resp_flg      (resp_flg),
    .jtlb_utlb_resp_pgs      (resp_pgs),
    .utlb_entry_upd          (entry_upd),
    .utlb_huge_entry_upd     (huge_upd),
    .utlb_upd_vpn            (upd_vpn),
    .utlb_upd_ppn            (upd_ppn),
    .utlb_upd_flg            (upd_flg),
    .utlb_upd_pgs            (upd_pgs),
    .utlb_refill_busy        (busy),
    .utlb_refill_done        (done),
    .utlb_refill_fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, want);
    end
  endtask

  // Victim rule: first invalid entry, else the round-robin slot
  function automatic logic [7:0] pick(input logic [7:0] vld, input int rr);
    for (int i = 0; i < 8; i++) if (!vld[i]) return 8'(1 << i);
    return 8'(1 << rr);
  endfunction

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    chk("busy",  32'(busy),      32'(exp_busy));
    chk("req",   32'(jtlb_req),  32'(exp_req));
    chk("done",  32'(done),      32'(exp_done));
    chk("fault", 32'(fault),     32'(exp_fault));
    chk("upd",   32'(entry_upd), 32'(exp_upd));
    chk("huge",  32'(huge_upd),  32'(exp_huge));
    if (exp_req) chk("jtlb_vpn", 32'(jtlb_vpn), 32'(exp_vpn));
    if (exp_data) begin
      chk("upd_vpn", 32'(upd_vpn), 32'(exp_vpn));
      chk("upd_ppn", 32'(upd_ppn), 32'(exp_ppn));
      chk("upd_flg", 32'(upd_flg), 32'(exp_flg));
      chk("upd_pgs", 32'(upd_pgs), 32'(exp_pgs));
    end
    if (done) begin
      seen_upd  = entry_upd;
      seen_huge = huge_upd;
    end
  end

  // advance one cycle; pulse inputs and pulse expectations fall back to 0
  task automatic tick();
    @(posedge clk);
    #1;
    grant = 0; resp_vld = 0; resp_fault = 0;
    regs_clr = 0; tlb_clr = 0; inv_req = 0;
    exp_req = 0; exp_done = 0; exp_fault = 0; exp_upd = '0; exp_huge = 0; exp_data = 0;
  endtask

  // One complete miss transaction; gdly/rdly = stall cycles before grant/resp
  task automatic refill(input logic [26:0] vpn, input logic [7:0] vld, input int gdly,
                        input int rdly, input logic flt, input logic [2:0] pgs,
                        input logic [27:0] ppn, input logic [13:0] flg,
                        output logic [7:0] p);
    logic hg;
    hg = (pgs == 3'b100);
    p = '0;
    seen_upd = '0; seen_huge = 0;
    exp_vpn = vpn; exp_ppn = ppn; exp_flg = flg; exp_pgs = pgs;
    miss_vld = 1; miss_vpn = vpn; entry_vld = vld; exp_busy = 0;
    tick();
    for (int k = 0; k <= gdly; k++) begin
      exp_busy = 1; exp_req = 1; grant = (k == gdly);
      if (k < gdly) begin resp_vld = 1; resp_fault = 1; end  // must be ignored in REQ
      tick();
    end
    for (int k = 0; k <= rdly; k++) begin
      exp_busy = 1;
      if (k == rdly) begin
        resp_vld = 1; resp_fault = flt; resp_ppn = ppn; resp_flg = flg; resp_pgs = pgs;
      end
      tick();
    end
    if (flt) begin
      exp_fault = 1; exp_busy = 0;
      tick();
    end else begin
      p = hg ? 8'h00 : pick(vld, model_rr);
      exp_upd = p; exp_huge = hg; exp_done = 1; exp_busy = 1; exp_data = 1;
      tick();
      if (!hg && vld == 8'hFF) model_rr = (model_rr + 1) % 8;
    end
    miss_vld = 0; exp_busy = 0;
    tick();
  endtask

  logic [7:0] rr_tab [9];

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    cpurst_b = 0; miss_vld = 0; miss_vpn = '0; entry_vld = '0;
    regs_clr = 0; tlb_clr = 0; inv_req = 0; grant = 0; resp_vld = 0; resp_fault = 0;
    resp_ppn = '0; resp_flg = '0; resp_pgs = '0;
    exp_busy = 0; exp_req = 0; exp_done = 0; exp_fault = 0; exp_upd = '0; exp_huge = 0;
    exp_data = 1; exp_vpn = '0; exp_ppn = '0; exp_flg = '0; exp_pgs = '0;
    model_rr = 0; seen_upd = '0; seen_huge = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cpurst_b = 1;
    tick();

    // basic 4K refill into empty array
    refill(27'h12345, 8'h00, 0, 0, 0, 3'b001, 28'hABCDE, 14'h0155, pred);
    chk("pin_basic_model", 32'(pred), 32'h01);
    chk("basic_seen_upd", 32'(seen_upd), 32'h01);

    // huge page: huge strobe only, pointer untouched
    refill(27'h7FC0123, 8'h00, 0, 0, 0, 3'b100, 28'h0FF0000, 14'h3FFF, pred);
    chk("huge_seen", 32'(seen_huge), 32'h1);
    chk("huge_seen_upd", 32'(seen_upd), 32'h00);

    // flush in the UPD cycle: strobe suppressed, pointer not advanced
    miss_vld = 1; miss_vpn = 27'h00ABC; entry_vld = 8'hFF; exp_busy = 0; tick();
    grant = 1; exp_req = 1; exp_vpn = 27'h00ABC; exp_busy = 1; tick();
    resp_vld = 1; resp_pgs = 3'b001; resp_ppn = 28'h1234; exp_busy = 1; tick();
    regs_clr = 1; exp_busy = 1; tick();
    miss_vld = 0; exp_busy = 0; tick();

    // round robin over a full array
    for (int n = 0; n < 9; n++) begin
      refill(27'h100 + 27'(n), 8'hFF, 0, 0, 0, 3'b001, 28'h200 + 28'(n), 14'(n), pred);
      chk("rr_pin_model", 32'(pred), 32'(rr_tab[n]));
      chk("rr_seen_upd", 32'(seen_upd), 32'(rr_tab[n]));
    end

    // fault: pulse, no update, miss still held in the pulse cycle is not retaken
    refill(27'h5555, 8'h00, 0, 1, 1, 3'b001, 28'h0, 14'h0, pred);
    chk("fault_seen_upd", 32'(seen_upd), 32'h00);

    // flush while waiting: response dropped three cycles later
    miss_vld = 1; miss_vpn = 27'h2222; entry_vld = 8'h00; exp_busy = 0; tick();
    grant = 1; exp_req = 1; exp_vpn = 27'h2222; exp_busy = 1; tick();
    tlb_clr = 1; miss_vld = 0; exp_busy = 1; tick();
    exp_busy = 1; tick();
    exp_busy = 1; tick();
    resp_vld = 1; resp_fault = 1; exp_busy = 1; tick();
    exp_busy = 0; tick();
    exp_busy = 0; tick();

    // flush in REQ returns to idle; flush in IDLE blocks capture
    miss_vld = 1; miss_vpn = 27'h3333; exp_busy = 0; tick();
    regs_clr = 1; miss_vld = 0; exp_req = 1; exp_vpn = 27'h3333; exp_busy = 1; tick();
    exp_busy = 0; tick();
    miss_vld = 1; inv_req = 1; exp_busy = 0; tick();
    miss_vld = 0; exp_busy = 0; tick();

    // grant stalled five cycles with stray responses, then slow response
    refill(27'h4444, 8'h0F, 5, 2, 0, 3'b010, 28'h7654321, 14'h2AAA, pred);
    chk("stall_pin_model", 32'(pred), 32'h10);
    chk("stall_seen_upd", 32'(seen_upd), 32'h10);

    // async reset mid-WAIT: everything back to zero at once
    miss_vld = 1; miss_vpn = 27'h6666; entry_vld = 8'hFF; exp_busy = 0; tick();
    grant = 1; exp_req = 1; exp_vpn = 27'h6666; exp_busy = 1; tick();
    cpurst_b = 0; miss_vld = 0; exp_busy = 0;
    exp_data = 1; exp_vpn = '0; exp_ppn = '0; exp_flg = '0; exp_pgs = '0;
    tick();
    cpurst_b = 1; exp_busy = 0; tick();
    model_rr = 0;

    // pointer restarted at entry 0
    refill(27'h7777, 8'hFF, 0, 0, 0, 3'b001, 28'h1111, 14'h0001, pred);
    chk("post_rst_pin_model", 32'(pred), 32'h01);
    chk("post_rst_seen_upd", 32'(seen_upd), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
